fpu_core: RTL and testbench

//  Memory-mapped IEEE-754 single-precision coprocessor on the CPU 8-bit bus.
//  CPU writes operand A and operand B bytewise, then writes an opcode. The block computes, raises busy, then cmd_end.
//  The result is read back bytewise. Blocks the CPU only by convention (busy poll or cmd_end IRQ).

---
 rtl/fpu_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fpu_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_core.sv
// fpu_core: byte-bus IEEE-754 single-precision coprocessor (add/sub/mul).
// The CPU loads A and B bytewise and writes an opcode to start. The core
// drops busy and raises cmd_end when the result is ready. Rounding truncates
// toward zero. Denormal operands are flushed to zero.
// Build option: define FPU_MUL_EN to include the shift-add multiplier.
// Without it, op_mul returns the quiet NaN and sets invalid.
module fpu_core (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  input  logic [5:0] addr,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       end_ack,
  output logic       cmd_end,
  output logic       busy
);

  localparam logic [7:0]  OP_ADD = 8'h00;
  localparam logic [7:0]  OP_SUB = 8'h01;
`ifdef FPU_MUL_EN
  localparam logic [7:0]  OP_MUL = 8'h02;
`endif
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_UNPACK  = 4'd1;
  localparam logic [3:0] S_SPECIAL = 4'd2;
  localparam logic [3:0] S_ALIGN   = 4'd3;
  localparam logic [3:0] S_ADDSUB  = 4'd4;
  localparam logic [3:0] S_MUL     = 4'd5;
  localparam logic [3:0] S_NORM    = 4'd6;
  localparam logic [3:0] S_PACK    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  // programmer-visible registers
  logic [31:0] a_reg, b_reg, res_reg;
  logic [7:0]  op_reg;
  logic        invalid, underflow, overflow;
  logic        op_strobe_q;

  // datapath working state
  logic [3:0]        state;
  logic              sa, sb, sr, eff_sub;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic signed [9:0] er;
  logic [27:0]       wm;   // normalised value has its leading 1 at bit 26
  logic [26:0]       sm;   // aligned smaller mantissa incl. 3 guard bits
  logic [31:0]       res_w;
  logic [2:0]        flg_w; // {invalid, underflow, overflow}

`ifdef FPU_MUL_EN
  logic [47:0] acc, mc, acc_nxt;
  logic [23:0] mq;
  logic [4:0]  cnt;
`endif

  // bus decode; the opcode start fires once per low strobe
  logic wr_en, op_strobe, start, op_ok;
  assign wr_en     = !cs && !wr;
  assign op_strobe = wr_en && (addr == 6'h08);
  assign start     = op_strobe && !op_strobe_q && !busy;

`ifdef FPU_MUL_EN
  assign op_ok = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_MUL);
  assign acc_nxt = acc + (mq[0] ? mc : 48'd0);
`else
  assign op_ok = (op_reg == OP_ADD) || (op_reg == OP_SUB);
`endif

  // alignment: order operands by magnitude so the subtraction never goes negative
  logic        a_big;
  logic [7:0]  ediff;
  logic [26:0] small27;
  assign a_big   = {ea, ma} >= {eb, mb};
  assign ediff   = a_big ? (ea - eb) : (eb - ea);
  assign small27 = a_big ? {mb, 3'b000} : {ma, 3'b000};

  // operand / opcode registers written from the CPU bus while idle
  always_ff @(posedge clk) begin
    if (arst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      op_strobe_q <= 1'b0;
    end else begin
      op_strobe_q <= op_strobe;
      if (wr_en && !busy) begin
        case (addr)
          6'h00: a_reg[7:0]   <= databus_in;
          6'h01: a_reg[15:8]  <= databus_in;
          6'h02: a_reg[23:16] <= databus_in;
          6'h03: a_reg[31:24] <= databus_in;
          6'h04: b_reg[7:0]   <= databus_in;
          6'h05: b_reg[15:8]  <= databus_in;
          6'h06: b_reg[23:16] <= databus_in;
          6'h07: b_reg[31:24] <= databus_in;
          6'h08: if (start) op_reg <= databus_in;
          default: ;
        endcase
      end
    end
  end

  // operation sequencer and arithmetic datapath
  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      cmd_end   <= 1'b0;
      invalid   <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      res_reg   <= '0;
      sa <= 1'b0; sb <= 1'b0; sr <= 1'b0; eff_sub <= 1'b0;
      ea <= '0; eb <= '0; ma <= '0; mb <= '0;
      er <= '0; wm <= '0; sm <= '0;
      res_w <= '0; flg_w <= '0;
`ifdef FPU_MUL_EN
      acc <= '0; mc <= '0; mq <= '0; cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cmd_end   <= 1'b0;
            invalid   <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            state     <= S_UNPACK;
          end else if (end_ack) begin
            cmd_end <= 1'b0;
          end
        end
        S_UNPACK: begin
          sa <= a_reg[31];
          sb <= b_reg[31] ^ (op_reg == OP_SUB);
          ea <= a_reg[30:23];
          eb <= b_reg[30:23];
          ma <= (a_reg[30:23] == 8'd0) ? 24'd0 : {1'b1, a_reg[22:0]};
          mb <= (b_reg[30:23] == 8'd0) ? 24'd0 : {1'b1, b_reg[22:0]};
          if (!op_ok) begin
            res_w <= QNAN;
            flg_w <= 3'b100;
            state <= S_DONE;
          end else begin
            state <= S_SPECIAL;
          end
        end
        S_SPECIAL: begin
          if (ea == 8'hFF || eb == 8'hFF) begin
            res_w <= QNAN;
            flg_w <= 3'b100;
            state <= S_DONE;
          end else begin
`ifdef FPU_MUL_EN
            if (op_reg == OP_MUL) begin
              acc   <= '0;
              mc    <= {24'd0, ma};
              mq    <= mb;
              cnt   <= '0;
              sr    <= sa ^ sb;
              er    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
              state <= S_MUL;
            end else
`endif
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          wm      <= {1'b0, (a_big ? ma : mb), 3'b000};
          er      <= $signed({2'b00, (a_big ? ea : eb)});
          sr      <= a_big ? sa : sb;
          eff_sub <= sa ^ sb;
          sm      <= (ediff >= 8'd26) ? 27'd0 : (small27 >> ediff);
          state   <= S_ADDSUB;
        end
        S_ADDSUB: begin
          wm    <= eff_sub ? (wm - {1'b0, sm}) : (wm + {1'b0, sm});
          state <= S_NORM;
        end
`ifdef FPU_MUL_EN
        S_MUL: begin
          acc <= acc_nxt;
          mc  <= mc << 1;
          mq  <= mq >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            wm    <= acc_nxt[47:20];
            state <= S_NORM;
          end
        end
`endif
        S_NORM: begin
          if (wm[27]) begin
            wm    <= wm >> 1;
            er    <= er + 10'sd1;
            state <= S_PACK;
          end else if (wm == 28'd0 || wm[26]) begin
            state <= S_PACK;
          end else begin
            wm <= wm << 1;
            er <= er - 10'sd1;
          end
        end
        S_PACK: begin
          if (wm == 28'd0) begin
            res_w <= 32'd0;
            flg_w <= 3'b000;
          end else if (er >= 10'sd255) begin
            res_w <= {sr, 8'hFF, 23'd0};
            flg_w <= 3'b001;
          end else if (er <= 10'sd0) begin
            res_w <= {sr, 31'd0};
            flg_w <= 3'b010;
          end else begin
            res_w <= {sr, er[7:0], wm[25:3]};
            flg_w <= 3'b000;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          res_reg   <= res_w;
          invalid   <= flg_w[2];
          underflow <= flg_w[1];
          overflow  <= flg_w[0];
          busy      <= 1'b0;
          cmd_end   <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // combinational read port
  always_comb begin
    databus_out = 8'h00;
    if (!cs && !rd) begin
      case (addr)
        6'h00: databus_out = a_reg[7:0];
        6'h01: databus_out = a_reg[15:8];
        6'h02: databus_out = a_reg[23:16];
        6'h03: databus_out = a_reg[31:24];
        6'h04: databus_out = b_reg[7:0];
        6'h05: databus_out = b_reg[15:8];
        6'h06: databus_out = b_reg[23:16];
        6'h07: databus_out = b_reg[31:24];
        6'h09: databus_out = res_reg[7:0];
        6'h0A: databus_out = res_reg[15:8];
        6'h0B: databus_out = res_reg[23:16];
        6'h0C: databus_out = res_reg[31:24];
        6'h0D: databus_out = {3'b000, invalid, underflow, overflow, cmd_end, busy};
        default: databus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_core.sv
// Directed-vector bench for fpu_core: a table of operand/opcode/expected
// result records plus hand sequences for reset, busy, strobe and ack corners.
module tb_fpu_core;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] databus_in = 8'h00;
  logic [7:0] databus_out;
  logic [5:0] addr = 6'h00;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, end_ack = 1'b0;
  logic       cmd_end, busy;

  int total = 0;
  int bad   = 0;

`ifdef FPU_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  fpu_core dut (
    .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
    .cmd_end(cmd_end), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [31:0] res;
    logic [2:0]  flg;  // {invalid, underflow, overflow}
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = a; databus_in = d;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; addr = a;
    #1 d = databus_out;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic rd_res(output logic [31:0] r);
    logic [7:0] t;
    for (int i = 0; i < 4; i++) begin
      bus_rd(6'(9 + i), t);
      r[8*i +: 8] = t;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!cmd_end && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk); end_ack = 1'b1;
    @(negedge clk); end_ack = 1'b0;
  endtask

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) bus_wr(6'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_wr(6'(4 + i), b[8*i +: 8]);
  endtask

  task automatic add_vec(input logic [31:0] a, b, input logic [7:0] op,
                         input logic [31:0] res, input logic [2:0] flg);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  st, d;
    int          lat, bound;
    bit          ok;

    // table of directed vectors
    add_vec(32'h40800000, 32'h41800000, 8'h01, 32'hC1400000, 3'b000); // 4-16
    add_vec(32'h3F800000, 32'h3F800000, 8'h00, 32'h40000000, 3'b000); // 1+1
    add_vec(32'h3F800000, 32'h3F800000, 8'h01, 32'h00000000, 3'b000); // 1-1 -> +0
    add_vec(32'hBF800000, 32'h40000000, 8'h00, 32'h3F800000, 3'b000); // -1+2
    add_vec(32'h7F000000, 32'h7F000000, 8'h00, 32'h7F800000, 3'b001); // overflow
    add_vec(32'hFF000000, 32'hFF000000, 8'h00, 32'hFF800000, 3'b001); // -overflow
    add_vec(32'h7F800000, 32'h3F800000, 8'h00, 32'h7FC00000, 3'b100); // Inf in
    add_vec(32'h3F800000, 32'h7F800000, 8'h01, 32'h7FC00000, 3'b100);
    add_vec(32'h7F800000, 32'h3F800000, 8'h02, 32'h7FC00000, 3'b100);
    add_vec(32'h3F800000, 32'h3F800000, 8'h05, 32'h7FC00000, 3'b100); // bad opcode
    add_vec(32'h00400000, 32'h3F800000, 8'h00, 32'h3F800000, 3'b000); // denormal flushed
    add_vec(32'h00800001, 32'h00800000, 8'h01, 32'h00000000, 3'b010); // underflow
    add_vec(32'h4B000000, 32'h3F800000, 8'h00, 32'h4B000001, 3'b000); // shift 23
    add_vec(32'h4B800000, 32'h3F800000, 8'h00, 32'h4B800000, 3'b000); // shift 24, truncated
    add_vec(32'h3F800000, 32'h33000000, 8'h01, 32'h3F7FFFFF, 3'b000); // shift 25, truncate
    add_vec(32'h3F800000, 32'h32800000, 8'h01, 32'h3F800000, 3'b000); // shift 26 -> larger
    add_vec(32'h40400000, 32'hC0000000, 8'h02,
            MUL ? 32'hC0C00000 : 32'h7FC00000, MUL ? 3'b000 : 3'b100);  // 3*-2
    add_vec(32'h3FC00000, 32'h3FC00000, 8'h02,
            MUL ? 32'h40100000 : 32'h7FC00000, MUL ? 3'b000 : 3'b100);  // 1.5*1.5
    add_vec(32'h7F000000, 32'h40000000, 8'h02,
            MUL ? 32'h7F800000 : 32'h7FC00000, MUL ? 3'b001 : 3'b100);
    add_vec(32'h00800000, 32'h00800000, 8'h02,
            MUL ? 32'h00000000 : 32'h7FC00000, MUL ? 3'b010 : 3'b100);
    add_vec(32'h00000000, 32'hC0000000, 8'h02,
            MUL ? 32'h00000000 : 32'h7FC00000, MUL ? 3'b000 : 3'b100);

    // reset state
    repeat (2) @(negedge clk);
    arst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset cmd_end", {31'd0, cmd_end}, 32'd0);
    chk("reset bus idle", {24'd0, databus_out}, 32'd0);
    bus_rd(6'h0D, st);
    chk("reset status", {24'd0, st}, 32'd0);
    rd_res(r);
    chk("reset result", r, 32'd0);

    // table-driven vectors
    foreach (vq[i]) begin
      load_ab(vq[i].a, vq[i].b);
      bus_wr(6'h08, vq[i].op);
      wait_done(lat);
      bound = (vq[i].op == 8'h02) ? 36 : 32;
      total++;
      if (lat > bound) begin
        bad++;
        $display("FAIL latency vec%0d: took %0d cycles, limit %0d", i, lat, bound);
      end
      rd_res(r);
      chk($sformatf("result vec%0d", i), r, vq[i].res);
      bus_rd(6'h0D, st);
      chk($sformatf("status vec%0d", i), {24'd0, st}, {27'd0, vq[i].flg, 2'b10});
      ack();
    end

    // A readback and unmapped / write-only addresses
    load_ab(32'h3F800000, 32'h3F800000);
    bus_rd(6'h03, d);
    chk("A byte3 readback", {24'd0, d}, 32'h3F);
    bus_rd(6'h20, d);
    chk("unmapped read", {24'd0, d}, 32'h00);
    bus_rd(6'h08, d);
    chk("opcode reads 0", {24'd0, d}, 32'h00);

    // writes during busy are ignored
    bus_wr(6'h08, 8'h00);
    chk("busy after start", {31'd0, busy}, 32'd1);
    bus_wr(6'h00, 8'hAB);
    bus_wr(6'h07, 8'h00);
    wait_done(lat);
    rd_res(r);
    chk("result w/ busy writes", r, 32'h40000000);
    bus_rd(6'h00, d);
    chk("A byte0 unchanged", {24'd0, d}, 32'h00);
    bus_rd(6'h07, d);
    chk("B byte3 unchanged", {24'd0, d}, 32'h3F);

    // cmd_end holds while idle, then clears on end_ack
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!cmd_end) ok = 1'b0;
    end
    chk("cmd_end held 5 cycles", {31'd0, ok}, 32'd1);
    @(negedge clk); end_ack = 1'b1;
    @(negedge clk); end_ack = 1'b0;
    chk("cmd_end after ack", {31'd0, cmd_end}, 32'd0);

    // start wins over end_ack in the same cycle
    bus_wr(6'h08, 8'h00);
    wait_done(lat);
    chk("cmd_end before start+ack", {31'd0, cmd_end}, 32'd1);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = 6'h08; databus_in = 8'h00; end_ack = 1'b1;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; end_ack = 1'b0;
    chk("start+ack busy", {31'd0, busy}, 32'd1);
    chk("start+ack cmd_end", {31'd0, cmd_end}, 32'd0);
    wait_done(lat);
    ack();

    // opcode strobe held low: exactly one start
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = 6'h08; databus_in = 8'h07;
    ok = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 3 && (busy || !cmd_end)) ok = 1'b0;
    end
    cs = 1'b1; wr = 1'b1;
    chk("held strobe single start", {31'd0, ok}, 32'd1);
    rd_res(r);
    chk("held strobe result", r, 32'h7FC00000);
    ack();

    // reset in the middle of an operation
    load_ab(32'h3F800000, 32'h3F800000);
    bus_wr(6'h08, 8'h00);
    repeat (4) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    chk("mid-op reset busy", {31'd0, busy}, 32'd0);
    chk("mid-op reset cmd_end", {31'd0, cmd_end}, 32'd0);
    rd_res(r);
    chk("mid-op reset result", r, 32'd0);
    bus_rd(6'h00, d);
    chk("mid-op reset A", {24'd0, d}, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cmd_end || busy) ok = 1'b0;
    end
    chk("no cmd_end after abort", {31'd0, ok}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
